// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, port owner
// encoding and the wait-counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_CORE,
    OWN_LOADER
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the core (0) and loader (1) ports.
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise port 0 has priority.
module mem_arb_pick (
  input  logic       valid0_i,
  input  logic       valid1_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       ptr_i,
`endif
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
    // ptr_i names the preferred port when both are requesting.
    if (valid0_i && valid1_i) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else begin
      grant_o = {valid1_i, valid0_i};
    end
`else
    grant_o = {valid1_i & ~valid0_i, valid0_i};
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the core and the loader/debug path,
// one transaction at a time. Optional macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic             write_q, write_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] grant;
  logic       idle;
  logic       accept;
  logic       capture;
  logic       clear_rd;
  logic       busy;

  assign idle       = (state_q == IDLE) && !reset;
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign accept     = req0_ready | req1_ready;

`ifdef ARB_ROUND_ROBIN_EN
  // ptr_q = 1 prefers the loader; it flips to the port not just granted.
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~req1_ready;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  mem_arb_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (ptr_q),
    .grant_o  (grant)
  );
`else
  mem_arb_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant_o  (grant)
  );
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = req1_ready ? OWN_LOADER : OWN_CORE;
          write_d = req1_ready ? req1_write : req0_write;
          addr_d  = req1_ready ? req1_addr : req0_addr;
          wdata_d = req1_ready ? req1_wdata : req0_wdata;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (write_q) begin
          mem_write = 1'b1;
          state_d   = RESP;
        end else begin
          mem_read = 1'b1;
          // The counter value seen here is MEM_LAT-1; zero means data is due now.
          if (cnt_q == '0) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_read = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_CORE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ACCESS) || (state_q == WAIT);
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = ((state_q == ACCESS) && write_q) ? wdata_q : '0;

  assign req0_rvalid = (state_q == RESP) && (owner_q == OWN_CORE);
  assign req1_rvalid = (state_q == RESP) && (owner_q == OWN_LOADER);

  // A store zeroes its owner's read-data register so the write response carries 0.
  assign clear_rd = (state_q == ACCESS) && write_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    localparam owner_e PORT_OWN = owner_e'(gi);
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        rdata_q <= '0;
      end else if ((capture || clear_rd) && (owner_q == PORT_OWN)) begin
        rdata_q <= capture ? mem_rdata : '0;
      end
    end
  end

  assign req0_rdata = g_rdata[0].rdata_q;
  assign req1_rdata = g_rdata[1].rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences and shares the single data memory port between two requesters: port 0 is the core load/store path and port 1 is the external loader/debug path. Each port uses a valid/ready request and a one-cycle response strobe. The block accepts one transaction at a time, drives the memory read/write strobes, waits a fixed latency and returns read data to the owning port. It sits between the core's ALU/register path and the data memory.

Parameters:
MEM_LAT, 1, cycles from the first mem_read cycle to the cycle whose mem_rdata is captured; legal range 1..15 (1 = combinational-read memory).
AW, 32, address width.
DW, 32, data width.

Ports:
clock  in  1  system clock; single clock domain; all logic on the rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  core request valid
req0_ready  out  1  core request accepted this cycle
req0_write  in  1  1 = store, 0 = load
req0_addr  in  AW  core address
req0_wdata  in  DW  core store data
req0_rvalid  out  1  core response strobe, one cycle
req0_rdata  out  DW  core load data
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, req1_rvalid, req1_rdata  same as port 0, for the loader/debug port
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE, the owner is 0 and the round-robin pointer points to port 0.
- FSM states:
  - IDLE: arbitrate. reqN_ready is asserted combinationally, only for the winner and only when that port's reqN_valid=1. On acceptance (valid&&ready), latch write, addr, wdata and owner, then go to ACCESS.
  - ACCESS: mem_addr and mem_wdata are driven from the latches.
    - Write: mem_write=1 for exactly this cycle, then go to RESP.
    - Read: mem_read=1 and the counter loads MEM_LAT-1. If MEM_LAT=1, capture mem_rdata at the end of this cycle and go to RESP; otherwise go to WAIT.
  - WAIT: mem_read stays 1 and mem_addr is held. The counter decrements each cycle. In the cycle where the count is 0, capture mem_rdata and go to RESP.
  - RESP: the owner's reqN_rvalid=1 for one cycle. reqN_rdata carries the captured data, or 0 for writes. Then go to IDLE.
- Latency from acceptance to rvalid is MEM_LAT+1 cycles for reads and 2 cycles for writes. Back-to-back transactions: the next acceptance occurs in the cycle after RESP.
- Default arbitration is fixed priority: port 0 wins whenever req0_valid=1.
- ready is never asserted outside IDLE. A requester holds valid and its payload until ready is seen. Dropping valid before acceptance is legal and leaves no state behind.
- rdata holds its value until the next capture. The non-owner's rvalid is always 0.
- mem_read and mem_write are never asserted together, and both are 0 in IDLE and RESP.
- Reset mid-transaction takes effect at the next edge: the FSM goes to IDLE and the strobes drop. The pending transaction is discarded and no rvalid is produced. A memory write whose ACCESS cycle has already completed stays committed.
- Addresses pass through unmodified; no alignment checks are made.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both ports are valid in IDLE, the winner is the port not granted last. The pointer updates on each acceptance. A single valid port always wins.
- Undefined: fixed priority with port 0 first; the pointer logic is not built.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, WAIT, RESP}
  - owner enum {OWN_CORE, OWN_LOADER}
  - localparam CNT_W = 4
- Sub-module mem_arb_pick (combinational): inputs are both valid bits and the pointer; output is the one-hot grant. Contains the fixed-priority/round-robin selection under the macro.

Test Plan:
1. Port 0 load, addr 0x10, memory holds 0xDEADBEEF at 0x10, MEM_LAT=1 -> mem_read high 1 cycle; req0_rvalid 2 cycles after acceptance; req0_rdata=0xDEADBEEF.
2. Port 1 store, addr 0x20, data 0x12345678, then port 1 load of 0x20 -> mem_write for exactly 1 cycle; store rvalid 2 cycles after acceptance; load returns 0x12345678.
3. Both ports valid every cycle for 4 transactions, default build -> all 4 grants to port 0. With ARB_ROUND_ROBIN_EN -> grants alternate 0,1,0,1.
4. MEM_LAT=3, port 0 load -> mem_read high 3 consecutive cycles with mem_addr stable; rvalid 4 cycles after acceptance; req1_ready stays 0 throughout.
5. reset asserted during WAIT (MEM_LAT=3) -> next cycle FSM in IDLE, all outputs 0, no rvalid; a new request is accepted after reset deasserts.
6. req1_valid raised for 1 cycle while busy, then dropped -> no acceptance and no memory access for port 1.
